// File: rtl/gamma_pkg.sv
// Shared types and constants for the gamma-cycle sequencer: state encoding,
// spike-time width derivation and the NO_SPIKE sentinel.
package gamma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GRST = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gamma_state_t;

    function automatic int gamma_tw(input int gamma_cycle_width);
        return $clog2(gamma_cycle_width);
    endfunction

    // All-ones spike time: "never pulses" on input, "y never seen" on output.
    function automatic int no_spike(input int tw);
        return (1 << tw) - 1;
    endfunction

endpackage

// File: rtl/gamma_pulse_gen.sv
// Drives one operator input as a fixed-width pulse starting at its spike time;
// the comparison is one bit wider than the time so the end point never wraps.
module gamma_pulse_gen
    import gamma_pkg::*;
#(
    parameter int TW          = 4,
    parameter int PULSE_WIDTH = 8
)(
    input  logic [TW-1:0] cnt,
    input  logic [TW-1:0] time_i,
    input  logic          run,
    output logic          pulse
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike(TW));
    localparam logic [TW:0]   PW_EXT   = (TW+1)'(PULSE_WIDTH);

    logic [TW:0] cnt_ext;
    logic [TW:0] start_ext;
    logic [TW:0] end_ext;

    assign cnt_ext   = {1'b0, cnt};
    assign start_ext = {1'b0, time_i};
    assign end_ext   = start_ext + PW_EXT;

    // Clipping at the end of RUN falls out of run dropping after the last count.
    assign pulse = run && (time_i != NO_SPIKE) &&
                   (cnt_ext >= start_ext) && (cnt_ext < end_ext);

endmodule

// File: rtl/gamma_sequencer.sv
// Gamma-cycle controller: IDLE -> GRST -> RUN -> DONE with valid/ready on both ends.
// Optional feature macro GAMMA_BACK2BACK_EN lets DONE hand straight over to GRST.
module gamma_sequencer
    import gamma_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int N_IN              = 2,
    localparam int TW               = gamma_tw(GAMMA_CYCLE_WIDTH)
)(
    input  logic               aclk,
    input  logic               grst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*TW-1:0] in_times,
    output logic               rst,
    output logic [N_IN-1:0]    pulse,
    input  logic               y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [TW-1:0]      res_time
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike(TW));
    localparam logic [TW-1:0] CNT_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

    gamma_state_t       state;
    gamma_state_t       next_state;
    logic [N_IN*TW-1:0] times_q;
    logic [TW-1:0]      cnt;
    logic               found;
    logic               accept;
    logic               run;

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs depend on state (and res_ready in back-to-back mode) only.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        rst        = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = GRST;
                end
            end
            GRST: begin
                rst        = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
`ifdef GAMMA_BACK2BACK_EN
                in_ready = res_ready;
                if (res_ready) begin
                    next_state = in_valid ? GRST : IDLE;
                end
`else
                if (res_ready) begin
                    next_state = IDLE;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    assign run    = (state == RUN);

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            times_q <= '1;
        end else if (accept) begin
            times_q <= in_times;
        end
    end

    // Counter wraps back to zero after the last RUN cycle since the width is a power of two.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt      <= '0;
            found    <= 1'b0;
            res_time <= NO_SPIKE;
        end else begin
            case (state)
                GRST: begin
                    cnt      <= '0;
                    found    <= 1'b0;
                    res_time <= NO_SPIKE;
                end
                RUN: begin
                    cnt <= cnt + TW'(1);
                    if (y && !found) begin
                        found    <= 1'b1;
                        res_time <= cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_channel
        gamma_pulse_gen #(
            .TW          (TW),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_pulse_gen (
            .cnt    (cnt),
            .time_i (times_q[i*TW +: TW]),
            .run    (run),
            .pulse  (pulse[i])
        );
    end

endmodule
